conv_mem_responder: RTL and testbench

- Synthesizable responder for the far end of the convolution engine's memory/handshake interface.
- Holds the input image ROM and the two banked layer memories (L0 = conv+ReLU output, L1 = max-pool output).
- Drives `ready`, watches `busy`, and services `iaddr`/`crd`/`cwr` traffic.
- After completion, exposes a host dump port and status counters. Used as the on-chip harness and FPGA wrapper for the engine.

---
 rtl/conv_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_conv_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_responder.sv
// Memory/handshake responder for the convolution engine: image ROM, L0/L1 layer banks,
// run-control FSM with timeout, host load/dump ports and per-run write counters.
module conv_mem_responder #(
  parameter int unsigned DW        = 20,
  parameter int unsigned IMG_DEPTH = 4096,
  parameter int unsigned L0_DEPTH  = 4096,
  parameter int unsigned L1_DEPTH  = 1024,
  parameter int unsigned TIMEOUT   = 262143
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [11:0]   load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [11:0]   iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [11:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [11:0]   caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          dump_sel,
  input  logic [11:0]   dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          done,
  output logic          timeout,
  output logic          err_csel,
  output logic [12:0]   l0_wr_cnt,
  output logic [10:0]   l1_wr_cnt
);

  localparam int unsigned IMG_AW = $clog2(IMG_DEPTH);
  localparam int unsigned L0_AW  = $clog2(L0_DEPTH);
  localparam int unsigned L1_AW  = $clog2(L1_DEPTH);
  localparam int unsigned TW     = $clog2(TIMEOUT + 1);
  localparam int unsigned L0_CW  = 13;
  localparam int unsigned L1_CW  = 11;
  localparam logic [2:0]  CSEL_L0 = 3'b001;
  localparam logic [2:0]  CSEL_L1 = 3'b011;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tcnt, tcnt_nxt;
  logic              busy_q;
  logic              ready_nxt, done_nxt, timeout_nxt, err_nxt;
  logic [L0_CW-1:0]  l0_nxt;
  logic [L1_CW-1:0]  l1_nxt;

  logic [DW-1:0] img_mem [IMG_DEPTH];
  logic [DW-1:0] l0_mem  [L0_DEPTH];
  logic [DW-1:0] l1_mem  [L1_DEPTH];

  logic host_ok, counting;
  logic img_we, l0_we, l1_we, bad_wr;

  assign host_ok  = (state == IDLE) || (state == DONE);
  assign counting = (state == ARM)  || (state == RUN);

  // Write decode: out-of-range or unmapped bank writes are dropped and flagged
  assign img_we = load_en && host_ok && (32'(load_addr) < IMG_DEPTH);
  assign l0_we  = cwr && (csel == CSEL_L0) && (32'(caddr_wr) < L0_DEPTH);
  assign l1_we  = cwr && (csel == CSEL_L1) && (32'(caddr_wr) < L1_DEPTH);
  assign bad_wr = cwr && !l0_we && !l1_we;

  // Memory arrays carry no reset so contents survive a mid-run reset
  always_ff @(posedge clk) begin
    if (img_we) img_mem[load_addr[IMG_AW-1:0]] <= load_data;
    if (l0_we)  l0_mem[caddr_wr[L0_AW-1:0]]    <= cdata_wr;
    if (l1_we)  l1_mem[caddr_wr[L1_AW-1:0]]    <= cdata_wr;
  end

  // Zero-latency read ports; a same-cycle write is only visible next cycle
  always_comb begin
    idata     = '0;
    cdata_rd  = '0;
    dump_data = '0;
    if (32'(iaddr) < IMG_DEPTH) idata = img_mem[iaddr[IMG_AW-1:0]];
    if (crd) begin
      if ((csel == CSEL_L0) && (32'(caddr_rd) < L0_DEPTH))
        cdata_rd = l0_mem[caddr_rd[L0_AW-1:0]];
      else if ((csel == CSEL_L1) && (32'(caddr_rd) < L1_DEPTH))
        cdata_rd = l1_mem[caddr_rd[L1_AW-1:0]];
    end
    if (!dump_sel) begin
      if (32'(dump_addr) < L0_DEPTH) dump_data = l0_mem[dump_addr[L0_AW-1:0]];
    end else begin
      if (32'(dump_addr) < L1_DEPTH) dump_data = l1_mem[dump_addr[L1_AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and next values of the registered status outputs
  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    done_nxt    = 1'b0;
    timeout_nxt = timeout;
    err_nxt     = err_csel | bad_wr;
    l0_nxt      = l0_wr_cnt;
    l1_nxt      = l1_wr_cnt;
    if (counting && l0_we && (l0_wr_cnt != '1)) l0_nxt = l0_wr_cnt + L0_CW'(1);
    if (counting && l1_we && (l1_wr_cnt != '1)) l1_nxt = l1_wr_cnt + L1_CW'(1);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt   = ARM;
          l0_nxt      = '0;
          l1_nxt      = '0;
          timeout_nxt = 1'b0;
          err_nxt     = 1'b0;
        end
      end
      ARM: begin
        tcnt_nxt = '0;
        if (busy && ready) state_nxt = RUN;
      end
      RUN: begin
        tcnt_nxt = tcnt + TW'(1);
        if (busy_q && !busy) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (tcnt >= TW'(TIMEOUT - 1)) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == ARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt      <= '0;
      busy_q    <= 1'b0;
      ready     <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_csel  <= 1'b0;
      l0_wr_cnt <= '0;
      l1_wr_cnt <= '0;
    end else begin
      tcnt      <= tcnt_nxt;
      busy_q    <= busy;
      ready     <= ready_nxt;
      done      <= done_nxt;
      timeout   <= timeout_nxt;
      err_csel  <= err_nxt;
      l0_wr_cnt <= l0_nxt;
      l1_wr_cnt <= l1_nxt;
    end
  end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Scoreboard bench for conv_mem_responder: stimulus pushes expectations from a memory-level
// reference model; an independent negedge monitor pops and compares them and the done pulses.
module tb_conv_mem_responder;

  localparam int unsigned DW = 28;
  localparam int unsigned TO = 6000;

  localparam int K_IDATA = 0, K_CDATA = 1, K_DUMP = 2, K_L0C = 3, K_L1C = 4;
  localparam int K_TO = 5, K_ERR = 6, K_READY = 7, K_DONE = 8, K_PEND = 9;

  logic          clk = 1'b0;
  logic          reset, load_en, start, busy, cwr, crd, dump_sel;
  logic [11:0]   load_addr, iaddr, caddr_wr, caddr_rd, dump_addr;
  logic [DW-1:0] load_data, cdata_wr;
  logic [2:0]    csel;
  logic          ready, done, timeout, err_csel;
  logic [DW-1:0] idata, cdata_rd, dump_data;
  logic [12:0]   l0_wr_cnt;
  logic [10:0]   l1_wr_cnt;

  conv_mem_responder #(.DW(DW), .IMG_DEPTH(4096), .L0_DEPTH(4096), .L1_DEPTH(1024),
                       .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata), .cwr(cwr),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
    .cdata_rd(cdata_rd), .csel(csel), .dump_sel(dump_sel), .dump_addr(dump_addr),
    .dump_data(dump_data), .done(done), .timeout(timeout), .err_csel(err_csel),
    .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct { int kind; logic [31:0] val; } chk_t;
  typedef struct { int cyc; int l0; int l1; } done_t;
  chk_t  exp_q[$];
  done_t done_q[$];

  int checks = 0, errors = 0;

  // Reference model: plain arrays and counters updated per spec rules
  logic [DW-1:0] img_m [4096];
  logic [DW-1:0] l0_m  [4096];
  logic [DW-1:0] l1_m  [1024];
  int l0c = 0, l1c = 0;
  bit counting = 0;

  function automatic string kname(int k);
    case (k)
      K_IDATA: return "idata";
      K_CDATA: return "cdata_rd";
      K_DUMP:  return "dump_data";
      K_L0C:   return "l0_wr_cnt";
      K_L1C:   return "l1_wr_cnt";
      K_TO:    return "timeout";
      K_ERR:   return "err_csel";
      K_READY: return "ready";
      K_DONE:  return "done";
      default: return "pending_done";
    endcase
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc_n, act, expv);
    end
  endtask

  // Monitor: compare every queued expectation against the live outputs, and each done pulse
  always @(negedge clk) begin
    chk_t c;
    done_t d;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      case (c.kind)
        K_IDATA: act = 32'(idata);
        K_CDATA: act = 32'(cdata_rd);
        K_DUMP:  act = 32'(dump_data);
        K_L0C:   act = 32'(l0_wr_cnt);
        K_L1C:   act = 32'(l1_wr_cnt);
        K_TO:    act = 32'(timeout);
        K_ERR:   act = 32'(err_csel);
        K_READY: act = 32'(ready);
        K_DONE:  act = 32'(done);
        default: act = 32'(done_q.size());
      endcase
      cmp(kname(c.kind), act, c.val);
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        cmp("unexpected_done", 32'(done), 32'd0);
      end else begin
        d = done_q.pop_front();
        cmp("done_cycle", 32'(cyc_n), 32'(d.cyc));
        cmp("done_l0_wr_cnt", 32'(l0_wr_cnt), 32'(d.l0));
        cmp("done_l1_wr_cnt", 32'(l1_wr_cnt), 32'(d.l1));
      end
    end
  end

  task automatic push(int k, logic [31:0] v);
    exp_q.push_back('{k, v});
  endtask

  function automatic logic [31:0] exp_cd(logic rd, logic [2:0] s, logic [11:0] a);
    if (!rd) return 32'd0;
    if (s == 3'b001) return 32'(l0_m[a]);
    if (s == 3'b011 && a < 12'd1024) return 32'(l1_m[a[9:0]]);
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_dump(logic s, logic [11:0] a);
    if (!s) return 32'(l0_m[a]);
    if (a < 12'd1024) return 32'(l1_m[a[9:0]]);
    return 32'd0;
  endfunction

  // One clock: the model absorbs what was driven this cycle, then returns 1ns after the edge
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      if (cwr) begin
        if (csel == 3'b001) begin
          l0_m[caddr_wr] = cdata_wr;
          if (counting && l0c < 8191) l0c++;
        end else if (csel == 3'b011 && caddr_wr < 12'd1024) begin
          l1_m[caddr_wr[9:0]] = cdata_wr;
          if (counting && l1c < 2047) l1c++;
        end
      end
      if (load_en && !counting) img_m[load_addr] = load_data;
      if (start && !counting) begin
        l0c = 0; l1c = 0; counting = 1;
      end
    end
    #1;
  endtask

  task automatic quiet();
    load_en = 0; start = 0; cwr = 0; crd = 0;
  endtask

  logic [11:0]   a;
  logic [DW-1:0] v;
  int            l1_keep;
  logic [2:0]    csel_tab [8];

  initial begin
    csel_tab = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b010, 3'b000, 3'b111, 3'b101};
    reset = 1; quiet(); busy = 0; iaddr = 0; caddr_wr = 0; caddr_rd = 0; csel = 3'b001;
    cdata_wr = 0; load_addr = 0; load_data = 0; dump_sel = 0; dump_addr = 0;
    step(); step();
    push(K_READY, 0); push(K_DONE, 0); push(K_TO, 0); push(K_ERR, 0);
    push(K_L0C, 0); push(K_L1C, 0);
    step();
    reset = 0;
    step();

    // Host image load, img[k] = k << 16
    for (int k = 0; k < 4096; k++) begin
      load_en = 1; load_addr = 12'(k); load_data = DW'(k << 16);
      step();
    end
    quiet();
    iaddr = 12'd65; push(K_IDATA, 32'h41_0000);
    step();
    for (int i = 0; i < 4; i++) begin
      a = 12'($urandom_range(0, 4095)); iaddr = a; push(K_IDATA, 32'(a) << 16);
      step();
    end

    // Run 1: ARM holds ready until busy is seen
    start = 1; step(); quiet();
    push(K_READY, 1); step();
    push(K_READY, 1); step();
    push(K_READY, 1);
    busy = 1; step();
    push(K_READY, 0);
    csel = 3'b001;
    for (int k = 0; k < 4096; k++) begin
      cwr = 1; caddr_wr = 12'(k); cdata_wr = DW'($urandom);
      crd = (k > 0); caddr_rd = (k > 0) ? 12'($urandom_range(0, k - 1)) : 12'd0;
      push(K_CDATA, exp_cd(crd, csel, caddr_rd));
      step();
    end
    csel = 3'b011;
    for (int k = 0; k < 1024; k++) begin
      cwr = 1; caddr_wr = 12'(k); cdata_wr = DW'($urandom);
      crd = (k > 0); caddr_rd = (k > 0) ? 12'($urandom_range(0, k - 1)) : 12'd0;
      push(K_CDATA, exp_cd(crd, csel, caddr_rd));
      step();
    end
    quiet();
    push(K_L0C, 32'd4096); push(K_L1C, 32'd1024);
    busy = 0; done_q.push_back('{cyc_n + 1, 4096, 1024});
    step(); counting = 0;
    push(K_READY, 0); step();

    // Host dump after completion, including L1 beyond its depth
    for (int i = 0; i < 12; i++) begin
      dump_sel = 1'($urandom); dump_addr = 12'($urandom_range(0, 4095));
      push(K_DUMP, exp_dump(dump_sel, dump_addr));
      step();
    end
    dump_sel = 1; dump_addr = 12'd2000; push(K_DUMP, 32'd0); step();

    // Same-cycle read/write of one address returns the old word
    csel = 3'b001; cwr = 1; crd = 1; caddr_wr = 12'd100; caddr_rd = 12'd100;
    cdata_wr = DW'(32'h12345);
    push(K_CDATA, exp_cd(1'b1, 3'b001, 12'd100));
    step();
    cwr = 0; push(K_CDATA, 32'h12345); push(K_L0C, 32'd4096);
    step(); quiet();

    // Run 2: illegal accesses, ignored host strobes, then randomized traffic
    start = 1; step(); quiet();
    busy = 1; step();
    push(K_READY, 0); push(K_ERR, 0);
    csel = 3'b010; cwr = 1; caddr_wr = 12'd7; cdata_wr = DW'(32'h777);
    step(); cwr = 0;
    push(K_ERR, 1); push(K_L0C, 0); push(K_L1C, 0);
    l1_keep = l1c;
    csel = 3'b011; cwr = 1; caddr_wr = 12'd1500; cdata_wr = DW'(32'h999);
    step(); cwr = 0;
    push(K_ERR, 1); push(K_L1C, 32'(l1_keep));
    csel = 3'b010; crd = 1; caddr_rd = 12'd7; push(K_CDATA, 0);
    step(); quiet();
    csel = 3'b011; crd = 1; caddr_rd = 12'd1500; push(K_CDATA, 0);
    step(); quiet();
    start = 1; step(); quiet();
    push(K_L0C, 32'(l0c)); push(K_ERR, 1); push(K_READY, 0);
    load_en = 1; load_addr = 12'd3; load_data = DW'(32'hABC); step(); quiet();
    iaddr = 12'd3; push(K_IDATA, 32'h3_0000);
    step();
    for (int i = 0; i < 300; i++) begin
      csel = csel_tab[$urandom_range(0, 7)];
      cwr = 1'($urandom); crd = 1'($urandom);
      caddr_wr = (csel == 3'b011 && $urandom_range(0, 7) != 0) ? 12'($urandom_range(0, 1023))
                                                               : 12'($urandom_range(0, 4095));
      caddr_rd = ($urandom_range(0, 1) != 0) ? caddr_wr : 12'($urandom_range(0, 4095));
      cdata_wr = DW'($urandom);
      push(K_CDATA, exp_cd(crd, csel, caddr_rd));
      step();
      push(K_L0C, 32'(l0c)); push(K_L1C, 32'(l1c));
    end
    quiet();
    busy = 0; done_q.push_back('{cyc_n + 1, l0c, l1c});
    step(); counting = 0;
    step();

    // Run 3: busy never drops, so the run aborts at the timeout limit
    start = 1; step(); quiet();
    busy = 1; step();
    for (int i = 1; i <= int'(TO); i++) begin
      step();
      if (i == int'(TO) - 1) push(K_TO, 0);
      if (i == int'(TO)) begin push(K_TO, 1); push(K_READY, 0); end
    end
    counting = 0;
    step(); busy = 0; step();
    push(K_TO, 1);

    // Run 4: start clears sticky flags; reset mid-run keeps memory contents
    start = 1; step(); quiet();
    push(K_TO, 0); push(K_ERR, 0); push(K_READY, 1); push(K_L0C, 0);
    busy = 1; csel = 3'b001; cwr = 1; caddr_wr = 12'd5; cdata_wr = DW'(32'h5A5A5);
    step(); quiet();
    push(K_L0C, 1); push(K_READY, 0);
    step(); step();
    reset = 1; busy = 0; counting = 0;
    #1;
    dump_sel = 0; dump_addr = 12'd5;
    push(K_READY, 0); push(K_L0C, 0); push(K_TO, 0); push(K_DUMP, 32'h5A5A5);
    step();
    reset = 0; step();
    push(K_DUMP, exp_dump(1'b0, 12'd5));
    start = 1; step(); quiet();
    push(K_READY, 1);
    step();
    push(K_PEND, 0);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
